serial_word_driver: RTL and testbench
=====================================

Name: serial_word_driver

Overview:
- Upstream stimulus stage for the serial sequence detectors (Mealy/Moore, overlap/non-overlap).
- Accepts parallel words over a valid/ready handshake and serialises them one bit per clock onto `x`. `x` feeds the detector's serial input directly.
- A one-word holding buffer lets consecutive words stream with no idle gap, so patterns that span word boundaries reach the detector intact.

Parameters:
- WIDTH, 8, bits per word (>=2).
- MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = din[0] first.
- IDLE_BIT, 0, level driven on `x` when no word is being shifted.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to serialise.
- din_valid  input  1  `din` is valid.
- din_ready  output  1  block can accept a word this cycle.
- en  input  1  shift enable; 0 stalls the shifter.
- x  output  1  serial bit to the detector.
- x_valid  output  1  `x` carries a payload bit this cycle.
- busy  output  1  a word is being shifted (state SHIFT).
- word_done  output  1  the last bit of the current word is on `x` and is consumed this cycle.

Behaviour:
- Registers:
  - state {IDLE, SHIFT}.
  - sreg[WIDTH-1:0] shift register.
  - cnt[$clog2(WIDTH)-1:0] bit index.
  - hold[WIDTH-1:0] holding buffer and hold_full flag.
- Reset (rst=0, async; takes effect immediately, including mid-word):
  - state=IDLE, cnt=0, sreg=0, hold_full=0.
  - Outputs: x=IDLE_BIT, x_valid=0, busy=0, word_done=0, din_ready=1.
  - Any partially shifted word and any held word are discarded.
- Outputs (combinational from flops only):
  - din_ready = !hold_full.
  - accept = din_valid && din_ready.
  - x = (state==SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT.
  - busy = (state==SHIFT).
  - x_valid = busy && en.
  - word_done = busy && en && (cnt==WIDTH-1).
- IDLE:
  - On accept: sreg<=din, cnt<=0, state<=SHIFT. The first bit appears on `x` in the cycle after the accepting edge (latency 1).
  - hold is unused in IDLE.
- SHIFT, en=0: sreg, cnt and state are frozen and `x` holds the current bit. An accept still loads hold (hold<=din, hold_full<=1).
- SHIFT, en=1, cnt<WIDTH-1:
  - sreg shifts toward the output end (MSB_FIRST: left; else right), zero-fill; cnt<=cnt+1.
  - An accept loads hold.
- SHIFT, en=1, cnt==WIDTH-1 (last bit), priority order:
  - hold_full: sreg<=hold, cnt<=0, stay SHIFT. If accept occurs in the same cycle it cannot, because din_ready=0, so hold_full<=0.
  - !hold_full and accept: sreg<=din directly, cnt<=0, stay SHIFT. This is the back-to-back case with no gap.
  - Otherwise: state<=IDLE, cnt<=0.
- Throughput: continuous valid input with en=1 gives exactly WIDTH x_valid cycles per word and zero idle cycles between words.
- Ordering: words are emitted in acceptance order; no word is dropped or duplicated.
- cnt never exceeds WIDTH-1; it wraps to 0 only through a reload or IDLE.

Test Plan:
1. WIDTH=8, MSB_FIRST=1. Release reset, present 8'hA5 for one cycle:
   - `x` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after accept.
   - word_done high only on the 8th cycle.
   - Then x=0 and busy=0.
2. Back-to-back 8'hAA then 8'h0A, din_valid held high:
   - Second word sits in hold; din_ready=0 until the first word's last bit.
   - 16 contiguous x_valid bits.
   - A downstream non-overlapping 1010 Mealy detector pulses y at bits 4, 8 and 16.
3. Stall: drop en for 3 cycles while bit index 3 of 8'hC3 is on `x`:
   - `x` holds that bit and x_valid=0 for those 3 cycles.
   - Word completes 11 cycles after the first bit.
4. MSB_FIRST=0, word 8'h01: `x` = 1 then seven 0s, word_done on the 8th bit.
5. Async reset pulse mid-word (at bit 5, hold_full=1):
   - x=IDLE_BIT, busy=0 and din_ready=1 immediately, without waiting for a clock edge.
   - After release, 8'hF0 shifts out as 1,1,1,1,0,0,0,0 with no remnant bits.
6. Simultaneous events: din_valid asserted with hold empty in the last-bit cycle:
   - New word loads directly, with no gap.
   - A third word offered during that same cycle's successor goes to hold and is emitted after, in order.

Source files
------------

// File: rtl/serial_word_driver.sv
// serial_word_driver: parallel-to-serial stimulus driver for the serial
// sequence detectors. Words arrive over valid/ready and leave one bit per
// clock on x. A one-word holding buffer lets consecutive words stream with
// no idle cycle between them.
module serial_word_driver #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_full, hold_full_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sreg_shifted;

  // Outputs are decoded from registered state (plus the en input).
  always_comb begin
    din_ready = !hold_full;
    accept    = din_valid && !hold_full;
    busy      = (state == SHIFT);
    x_valid   = busy && en;
    last_bit  = (cnt == LAST);
    word_done = busy && en && last_bit;
    if (state == SHIFT) x = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    else                x = IDLE_BIT;
    if (MSB_FIRST) sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    else           sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
  end

  // Next-state logic: load/shift/reload decisions for sreg, cnt and hold.
  always_comb begin
    state_nxt     = state;
    sreg_nxt      = sreg;
    cnt_nxt       = cnt;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_nxt  = din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (en && last_bit) begin
          // Held word has priority; accept cannot coincide since din_ready=0.
          if (hold_full) begin
            sreg_nxt      = hold;
            cnt_nxt       = '0;
            hold_full_nxt = 1'b0;
          end else if (accept) begin
            sreg_nxt = din;
            cnt_nxt  = '0;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          if (en) begin
            sreg_nxt = sreg_shifted;
            cnt_nxt  = cnt + 1'b1;
          end
          if (accept) begin
            hold_nxt      = din;
            hold_full_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
    end
  end

endmodule

// File: tb/tb_serial_word_driver.sv
// Directed self-checking bench for serial_word_driver: one MSB-first instance
// (IDLE_BIT=0) and one LSB-first instance (IDLE_BIT=1).
module tb_serial_word_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       en = 1'b1;
  logic       x, x_valid, busy, word_done;

  logic [7:0] din2 = '0;
  logic       din_valid2 = 1'b0;
  logic       din_ready2;
  logic       en2 = 1'b1;
  logic       x2, x_valid2, busy2, word_done2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  serial_word_driver #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .en(en), .x(x), .x_valid(x_valid), .busy(busy), .word_done(word_done)
  );

  serial_word_driver #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2), .din_ready(din_ready2),
    .en(en2), .x(x2), .x_valid(x_valid2), .busy(busy2), .word_done(word_done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams nbits from seq (first bit = seq[nbits-1]) on the MSB-first DUT.
  // The first word must already be accepted. Optional offers at bit indices
  // off0/off1; rdy_exp[k] is the expected din_ready at bit k. y_mask collects
  // pulses of a non-overlapping 1010 Mealy detector fed from x.
  task automatic shift_check(input string tag, input logic [31:0] seq, input int nbits,
                             input int off0, input logic [7:0] w0,
                             input int off1, input logic [7:0] w1,
                             input logic [31:0] rdy_exp, output logic [31:0] y_mask);
    int ds;
    ds = 0;
    y_mask = '0;
    for (int k = 0; k < nbits; k++) begin
      din_valid = (k == off0) || (k == off1);
      din       = (k == off1) ? w1 : w0;
      en        = 1'b1;
      #1;
      check({tag, ".x"},         {31'd0, x},         {31'd0, seq[nbits-1-k]});
      check({tag, ".x_valid"},   {31'd0, x_valid},   32'd1);
      check({tag, ".busy"},      {31'd0, busy},      32'd1);
      check({tag, ".word_done"}, {31'd0, word_done}, {31'd0, (k % 8) == 7});
      check({tag, ".din_ready"}, {31'd0, din_ready}, {31'd0, rdy_exp[k]});
      if (x_valid) begin
        case (ds)
          0: ds = x ? 1 : 0;
          1: ds = x ? 1 : 2;
          2: ds = x ? 3 : 0;
          default: begin
            if (!x) y_mask[k] = 1'b1;
            ds = x ? 1 : 0;
          end
        endcase
      end
      tick();
    end
    din_valid = 1'b0;
    #1;
    check({tag, ".end_busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".end_x"},    {31'd0, x},    32'd0);
  endtask

  task automatic accept_msb(input logic [7:0] w);
    din = w;
    din_valid = 1'b1;
    en = 1'b1;
    #1;
    check("accept.din_ready", {31'd0, din_ready}, 32'd1);
    tick();
    din_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ym;
    logic [7:0]  w;
    int          bi;

    // Reset state.
    #1 rst = 1'b0;
    #2;
    check("rst.x",         {31'd0, x},          32'd0);
    check("rst.busy",      {31'd0, busy},       32'd0);
    check("rst.din_ready", {31'd0, din_ready},  32'd1);
    check("rst.x_valid",   {31'd0, x_valid},    32'd0);
    check("rst.word_done", {31'd0, word_done},  32'd0);
    check("rst.x2",        {31'd0, x2},         32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: single word A5, MSB first.
    accept_msb(8'hA5);
    shift_check("t1", 32'h0000_00A5, 8, -1, 8'h00, -1, 8'h00, 32'hFF, ym);

    // 2: AA then 0A back to back through hold; detector pulses at bits 4, 8, 16.
    accept_msb(8'hAA);
    shift_check("t2", 32'h0000_AA0A, 16, 0, 8'h0A, -1, 8'h00, 32'hFF01, ym);
    check("t2.detector", ym, 32'h8088);

    // 3: stall 3 cycles while bit index 3 of C3 is on x; completes in 11 cycles.
    accept_msb(8'hC3);
    w = 8'hC3;
    bi = 0;
    for (int c = 0; c < 11; c++) begin
      en = !(c >= 3 && c < 6);
      #1;
      check("t3.busy", {31'd0, busy}, 32'd1);
      if (en) begin
        check("t3.x",         {31'd0, x},         {31'd0, w[7-bi]});
        check("t3.x_valid",   {31'd0, x_valid},   32'd1);
        check("t3.word_done", {31'd0, word_done}, {31'd0, c == 10});
        bi++;
      end else begin
        check("t3.stall_x",       {31'd0, x},         {31'd0, w[4]});
        check("t3.stall_x_valid", {31'd0, x_valid},   32'd0);
        check("t3.stall_done",    {31'd0, word_done}, 32'd0);
      end
      tick();
    end
    en = 1'b1;
    #1;
    check("t3.end_busy", {31'd0, busy}, 32'd0);

    // 4: LSB-first instance, words 01 and B2.
    for (int n = 0; n < 2; n++) begin
      w = (n == 0) ? 8'h01 : 8'hB2;
      din2 = w;
      din_valid2 = 1'b1;
      #1;
      check("t4.idle_x2", {31'd0, x2}, 32'd1);
      tick();
      din_valid2 = 1'b0;
      for (int k = 0; k < 8; k++) begin
        #1;
        check("t4.x2",         {31'd0, x2},         {31'd0, w[k]});
        check("t4.x_valid2",   {31'd0, x_valid2},   32'd1);
        check("t4.word_done2", {31'd0, word_done2}, {31'd0, k == 7});
        tick();
      end
      #1;
      check("t4.end_busy2", {31'd0, busy2}, 32'd0);
      check("t4.end_x2",    {31'd0, x2},    32'd1);
    end

    // 5: async reset at bit 5 with hold full, then F0 with no remnants.
    accept_msb(8'h3C);
    for (int k = 0; k < 5; k++) begin
      din_valid = (k == 0);
      din = 8'hFF;
      tick();
    end
    din_valid = 1'b0;
    #1;
    check("t5.pre_busy",      {31'd0, busy},      32'd1);
    check("t5.pre_din_ready", {31'd0, din_ready}, 32'd0);
    check("t5.pre_x",         {31'd0, x},         32'd1);
    rst = 1'b0;
    #1;
    check("t5.rst_x",         {31'd0, x},         32'd0);
    check("t5.rst_busy",      {31'd0, busy},      32'd0);
    check("t5.rst_din_ready", {31'd0, din_ready}, 32'd1);
    check("t5.rst_x_valid",   {31'd0, x_valid},   32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    #1;
    check("t5.idle_busy", {31'd0, busy}, 32'd0);
    accept_msb(8'hF0);
    shift_check("t5", 32'h0000_00F0, 8, -1, 8'h00, -1, 8'h00, 32'hFF, ym);
    tick();
    #1;
    check("t5.no_remnant", {31'd0, busy}, 32'd0);

    // 6: direct load in last-bit cycle (hold empty), third word held after it.
    accept_msb(8'h81);
    shift_check("t6", 32'h0081_5AE7, 24, 7, 8'h5A, 8, 8'hE7, 32'hFF_01FF, ym);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
